// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory request/acknowledge plus the
// valid/ready delivery and redirect channels toward execute.
interface instr_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        output instr_valid, instr, instr_pc,
        input  instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        input  instr_valid, instr, instr_pc,
        output instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one memory read in flight and
// buffers returned words in a shift-style prefetch queue whose slot 0 is the head.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_BUSY,
        REQ_SQUASH
    } req_state_t;

    req_state_t       req_state_reg, req_state_next, req_state_settled;
    logic [31:0]      fetch_pc_reg, fetch_pc_next;
    logic             mem_req_reg;
    logic [31:0]      mem_addr_reg, mem_addr_next;
    logic [CW-1:0]    count_reg, count_next, push_slot;
    logic [31:0]      q_instr_reg [DEPTH];
    logic [31:0]      q_instr_next [DEPTH];
    logic [31:0]      q_pc_reg [DEPTH];
    logic [31:0]      q_pc_next [DEPTH];
    logic [DEPTH-1:0] q_valid_reg, q_valid_next;
    logic             flush, pop, push, issue;
    logic             unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    // A redirect flushes everything and overrides any pop or push this cycle.
    always_comb begin
        flush         = bus.redirect_valid;
        pop           = q_valid_reg[0] && bus.instr_ready && !flush;
        push          = (req_state_reg == REQ_BUSY) && bus.mem_ack && !flush;
        fetch_pc_next = fetch_pc_reg;
        if (flush) begin
            fetch_pc_next = {bus.redirect_pc[31:2], 2'b00};
        end else if (push) begin
            fetch_pc_next = mem_addr_reg + 32'd4;
        end
        push_slot  = count_reg - CW'(pop);
        count_next = flush ? '0 : (count_reg - CW'(pop) + CW'(push));
    end

    // Request tracker; SQUASH marks an in-flight read whose data is stale.
    always_comb begin
        req_state_settled = req_state_reg;
        case (req_state_reg)
            REQ_BUSY: begin
                if (bus.mem_ack) begin
                    req_state_settled = REQ_IDLE;
                end else if (flush) begin
                    req_state_settled = REQ_SQUASH;
                end
            end
            REQ_SQUASH: begin
                if (bus.mem_ack) begin
                    req_state_settled = REQ_IDLE;
                end
            end
            default: begin
            end
        endcase
        issue          = (req_state_settled == REQ_IDLE) && (count_next < CW'(DEPTH));
        req_state_next = issue ? REQ_BUSY : req_state_settled;
        mem_addr_next  = issue ? fetch_pc_next : mem_addr_reg;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [31:0] up_instr;
            logic [31:0] up_pc;
            logic        load_new;

            if (gi < DEPTH - 1) begin : g_shift
                assign up_instr = q_instr_reg[gi + 1];
                assign up_pc    = q_pc_reg[gi + 1];
            end else begin : g_top
                assign up_instr = q_instr_reg[gi];
                assign up_pc    = q_pc_reg[gi];
            end

            // The incoming word lands just above the surviving entries.
            assign load_new = push && (push_slot == CW'(gi));

            assign q_instr_next[gi] = flush    ? q_instr_reg[gi] :
                                      load_new ? bus.mem_rdata   :
                                      pop      ? up_instr        : q_instr_reg[gi];
            assign q_pc_next[gi]    = flush    ? q_pc_reg[gi]    :
                                      load_new ? mem_addr_reg    :
                                      pop      ? up_pc           : q_pc_reg[gi];
            assign q_valid_next[gi] = CW'(gi) < count_next;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            req_state_reg <= REQ_IDLE;
            fetch_pc_reg  <= RESET_PC;
            mem_req_reg   <= 1'b0;
            mem_addr_reg  <= RESET_PC;
            count_reg     <= '0;
            q_valid_reg   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr_reg[i] <= '0;
                q_pc_reg[i]    <= '0;
            end
        end else begin
            req_state_reg <= req_state_next;
            fetch_pc_reg  <= fetch_pc_next;
            mem_req_reg   <= (req_state_next != REQ_IDLE);
            mem_addr_reg  <= mem_addr_next;
            count_reg     <= count_next;
            q_valid_reg   <= q_valid_next;
            for (int i = 0; i < DEPTH; i++) begin
                q_instr_reg[i] <= q_instr_next[i];
                q_pc_reg[i]    <= q_pc_next[i];
            end
        end
    end

    assign bus.mem_req     = mem_req_reg;
    assign bus.mem_addr    = mem_addr_reg;
    assign bus.instr_valid = q_valid_reg[0];
    assign bus.instr       = q_instr_reg[0];
    assign bus.instr_pc    = q_pc_reg[0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a byte-array memory model
// that supports a configurable number of wait cycles.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_if mif();

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(mif)
    );

    logic [7:0]  mem_bytes [256];
    int          wait_cycles = 0;
    int          wait_cnt    = 0;
    int          fetch_cnt   = 0;
    int          checks      = 0;
    int          errors      = 0;
    int          base_cnt;
    int          n;
    logic [31:0] acc_q [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem_bytes[b + 8'd3], mem_bytes[b + 8'd2], mem_bytes[b + 8'd1], mem_bytes[b]};
    endfunction

    task automatic mem_update();
        if (!mif.mem_req) begin
            wait_cnt      = 0;
            mif.mem_ack   = 1'b0;
            mif.mem_rdata = 32'd0;
        end else if (wait_cnt >= wait_cycles) begin
            mif.mem_ack   = 1'b1;
            mif.mem_rdata = mem_word(mif.mem_addr);
            wait_cnt      = 0;
            fetch_cnt++;
        end else begin
            mif.mem_ack = 1'b0;
            wait_cnt++;
        end
    endtask

    // Log what execute accepts at the coming edge, then advance one cycle.
    task automatic tick();
        if (mif.instr_valid && mif.instr_ready && !mif.redirect_valid)
            acc_q.push_back(mif.instr_pc);
        @(negedge clk);
        mem_update();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mif.instr_ready    = 1'b0;
        mif.redirect_valid = 1'b0;
        mif.redirect_pc    = 32'd0;
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_bytes[i] = 8'(i) ^ 8'hA5;
        mem_bytes[4] = 8'h22;
        mem_bytes[5] = 8'h20;
        mem_bytes[6] = 8'h43;
        mem_bytes[7] = 8'h00;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 32'd0;

        // Reset state
        do_reset();
        check("rst_mem_req", 32'(mif.mem_req), 32'd0);
        check("rst_mem_addr", mif.mem_addr, 32'h0);
        check("rst_valid", 32'(mif.instr_valid), 32'd0);
        check("rst_instr", mif.instr, 32'd0);
        check("rst_instr_pc", mif.instr_pc, 32'd0);

        // Free run, zero-wait memory
        rst = 1'b0;
        mif.instr_ready = 1'b1;
        tick();
        check("fr_req_e0", 32'(mif.mem_req), 32'd1);
        check("fr_addr_e0", mif.mem_addr, 32'h0);
        check("fr_valid_e0", 32'(mif.instr_valid), 32'd0);
        tick();
        check("fr_valid_e1", 32'(mif.instr_valid), 32'd1);
        check("fr_pc0", mif.instr_pc, 32'h0);
        check("fr_instr0", mif.instr, 32'hA6A7_A4A5);
        tick();
        check("fr_pc4", mif.instr_pc, 32'h4);
        check("fr_instr4", mif.instr, 32'h0043_2022);
        tick();
        check("fr_pc8", mif.instr_pc, 32'h8);
        check("fr_instr8", mif.instr, 32'hAEAF_ACAD);
        tick();
        check("fr_pc12", mif.instr_pc, 32'hC);
        check("fr_instr12", mif.instr, 32'hAAAB_A8A9);

        // Backpressure: ready low for 5 cycles
        do_reset();
        rst = 1'b0;
        base_cnt = fetch_cnt;
        tick();
        tick();
        check("bp_addr4", mif.mem_addr, 32'h4);
        tick();
        tick();
        tick();
        check("bp_req_idle", 32'(mif.mem_req), 32'd0);
        check("bp_fetches", 32'(fetch_cnt - base_cnt), 32'd2);
        check("bp_head0", mif.instr_pc, 32'h0);
        mif.instr_ready = 1'b1;
        acc_q.delete();
        tick();
        check("bp_req_resume", 32'(mif.mem_req), 32'd1);
        check("bp_addr8", mif.mem_addr, 32'h8);
        check("bp_head4", mif.instr_pc, 32'h4);
        tick();
        tick();
        mif.instr_ready = 1'b0;
        check("bp_acc_n", 32'(acc_q.size()), 32'd3);
        check("bp_acc0", acc_q[0], 32'h0);
        check("bp_acc1", acc_q[1], 32'h4);
        check("bp_acc2", acc_q[2], 32'h8);

        // Redirect with queue holding PCs 8 and 12
        do_reset();
        rst = 1'b0;
        mif.instr_ready = 1'b1;
        acc_q.delete();
        tick();
        tick();
        tick();
        tick();
        mif.instr_ready = 1'b0;
        tick();
        check("rd_head8", mif.instr_pc, 32'h8);
        check("rd_req_full", 32'(mif.mem_req), 32'd0);
        mif.redirect_valid = 1'b1;
        mif.redirect_pc    = 32'h0000_0020;
        mif.instr_ready    = 1'b1;
        tick();
        mif.redirect_valid = 1'b0;
        mif.redirect_pc    = 32'd0;
        check("rd_flushed", 32'(mif.instr_valid), 32'd0);
        check("rd_addr20", mif.mem_addr, 32'h20);
        tick();
        mif.instr_ready = 1'b0;
        check("rd_valid", 32'(mif.instr_valid), 32'd1);
        check("rd_pc20", mif.instr_pc, 32'h20);
        check("rd_acc_n", 32'(acc_q.size()), 32'd2);
        check("rd_acc1", acc_q[1], 32'h4);

        // 3-wait memory, redirect while the 0x10 read is in flight
        do_reset();
        wait_cycles = 3;
        rst = 1'b0;
        acc_q.delete();
        repeat (9) tick();
        check("ws_req_full", 32'(mif.mem_req), 32'd0);
        check("ws_head0", mif.instr_pc, 32'h0);
        mif.redirect_valid = 1'b1;
        mif.redirect_pc    = 32'h0000_0010;
        tick();
        mif.redirect_valid = 1'b0;
        check("ws_addr10", mif.mem_addr, 32'h10);
        tick();
        mif.redirect_valid = 1'b1;
        mif.redirect_pc    = 32'h0000_0040;
        mif.instr_ready    = 1'b1;
        tick();
        mif.redirect_valid = 1'b0;
        mif.redirect_pc    = 32'd0;
        check("ws_addr_hold", mif.mem_addr, 32'h10);
        check("ws_req_hold", 32'(mif.mem_req), 32'd1);
        tick();
        tick();
        check("ws_addr40", mif.mem_addr, 32'h40);
        check("ws_no_stale", 32'(mif.instr_valid), 32'd0);
        n = 0;
        for (int i = 0; i < 20 && !mif.instr_valid; i++) begin
            tick();
            n++;
        end
        check("ws_valid", 32'(mif.instr_valid), 32'd1);
        check("ws_latency", 32'(n), 32'd4);
        check("ws_pc40", mif.instr_pc, 32'h40);
        check("ws_instr40", mif.instr, 32'hE6E7_E4E5);
        check("ws_acc_n", 32'(acc_q.size()), 32'd0);

        // PC wrap-around after redirect to 0xFFFF_FFFE
        do_reset();
        wait_cycles = 0;
        rst = 1'b0;
        mif.instr_ready = 1'b1;
        tick();
        tick();
        tick();
        mif.redirect_valid = 1'b1;
        mif.redirect_pc    = 32'hFFFF_FFFE;
        tick();
        mif.redirect_valid = 1'b0;
        mif.redirect_pc    = 32'd0;
        check("wr_addr_top", mif.mem_addr, 32'hFFFF_FFFC);
        check("wr_flushed", 32'(mif.instr_valid), 32'd0);
        tick();
        check("wr_addr_zero", mif.mem_addr, 32'h0);
        check("wr_pc_top", mif.instr_pc, 32'hFFFF_FFFC);
        check("wr_instr_top", mif.instr, 32'h5A5B_5859);
        tick();
        check("wr_pc_zero", mif.instr_pc, 32'h0);

        // Reset while a read is being acknowledged
        do_reset();
        wait_cycles = 3;
        rst = 1'b0;
        repeat (9) tick();
        check("mr_full_valid", 32'(mif.instr_valid), 32'd1);
        mif.instr_ready = 1'b1;
        tick();
        mif.instr_ready = 1'b0;
        check("mr_addr8", mif.mem_addr, 32'h8);
        tick();
        tick();
        tick();
        check("mr_ack_pending", 32'(mif.mem_ack), 32'd1);
        rst = 1'b1;
        tick();
        check("mr_valid", 32'(mif.instr_valid), 32'd0);
        check("mr_req", 32'(mif.mem_req), 32'd0);
        check("mr_pc", mif.instr_pc, 32'd0);
        check("mr_addr", mif.mem_addr, 32'h0);
        rst = 1'b0;
        tick();
        check("mr_req_restart", 32'(mif.mem_req), 32'd1);
        check("mr_addr_restart", mif.mem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
